mat_fifo_wr_arb: RTL and testbench
==================================

# mat_fifo_wr_arb

Two-requester burst write arbiter in front of the synchronous `mat_fifo` (SYNC_FIFO, ADDR_WIDTH 10, DATA_WIDTH 8).
- It grants the FIFO write port to one source for a whole burst of declared length.
- It forwards that source's beats to the FIFO under full-flag back-pressure.
- It alternates grants round-robin when both sources request.
- It sits between the pixel producers (e.g. two line readers) and the shared matrix FIFO.

## Interface
- `DATA_WIDTH`, 8, pixel word width.
- `LEN_WIDTH`, 10, width of burst length field; length field = words − 1, so max burst is 2**LEN_WIDTH words.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s0_req`, `s1_req`  in  1  burst request, held until granted.
- `s0_len`, `s1_len`  in  LEN_WIDTH  burst words − 1, sampled at grant.
- `s0_valid`, `s1_valid`  in  1  beat valid.
- `s0_data`, `s1_data`  in  DATA_WIDTH  beat data.
- `s0_ready`, `s1_ready`  out  1  beat accepted when valid && ready.
- `s0_done`, `s1_done`  out  1  one-cycle pulse after the last beat of the source's burst.
- `fifo_wr_en`  out  1  to `mat_fifo` wr_en.
- `fifo_wr_data`  out  DATA_WIDTH (+1 with tag)  to `mat_fifo` wr_data.
- `fifo_full`  in  1  from `mat_fifo` full.
- `busy`  out  1  high in BURST.
- `cur_src`  out  1  granted source index, valid while busy.

## Operation
- FSM states: IDLE, BURST, DONE.
- **IDLE**: if any req is high, pick a source and latch its len into `len_q`. Clear `beat_cnt`, set `cur_src`, then go to BURST.
- **Source pick**: a single requester wins outright. If both request, the winner is the source opposite `last_src`. `last_src` resets to 1, so s0 wins the first tie.
- **BURST** handshake:
  - `sN_ready` = (cur_src==N) && !fifo_full; the other source's ready is 0.
  - `fifo_wr_en` = granted valid && ready.
  - `fifo_wr_data` = granted data, muxed combinationally; 0 outside BURST.
  - `beat_cnt` increments per accepted beat.
  - The beat with `beat_cnt`==`len_q` is the last: go to DONE and update `last_src` ← `cur_src`.
- **DONE**: assert `s{cur_src}_done` for one cycle, then go to IDLE.
- Requests are ignored outside IDLE. A requester must drop req at or before its done pulse, or it is re-arbitrated.
- valid low or fifo_full high stalls the burst indefinitely, with no timeout.
- `beat_cnt` and `len_q` are LEN_WIDTH wide. len = all-ones gives 2**LEN_WIDTH beats, and `beat_cnt` never wraps inside a burst.
- **Reset mid-burst**: everything clears immediately, the burst is abandoned, and no done pulse is issued. The FIFO contents are the owner's concern.

## Timing
- Reset values: state IDLE, all ready/done/`fifo_wr_en`/`busy` 0, `fifo_wr_data` 0, `cur_src` 0, `last_src` 1, counters 0.
- **Grant latency**: req seen high at edge k → BURST after edge k → ready can be high in cycle k+1.
- **Beats**: zero added latency. `fifo_wr_en` is combinational from valid/ready/full, so the FIFO write occurs at the same edge as the handshake.
- **Throughput**: 1 beat/cycle within a burst. Overhead is 2 cycles per burst (DONE + IDLE arbitration), so a burst of N words occupies N+2 cycles minimum.
- `fifo_full` rising mid-cycle drops ready in the same cycle (combinational path full→ready).

## Configuration
- `MAT_FIFO_ARB_TAG_EN` defined: `fifo_wr_data` is DATA_WIDTH+1 bits, with MSB = `cur_src`. The FIFO instance is built with DATA_WIDTH+1, letting the reader demultiplex sources.
- Undefined: `fifo_wr_data` is DATA_WIDTH bits of pure data, and the reader relies on burst order only.

## Structure
- Package `mat_fifo_pkg`: FSM state encodings (IDLE/BURST/DONE), source index constants SRC0/SRC1, default LEN_WIDTH.
- One sub-module `rr_arb2`: combinational two-way round-robin pick from (req0, req1, last_src) → (gnt_valid, gnt_idx). The top module holds the FSM, counters and datapath mux.

## Test plan
- **Single burst**: s0_req, len=15, valid every cycle, full=0 → 16 fifo_wr_en beats carrying data 1..16, `s0_done` one cycle after beat 16, `busy` low 1 cycle later.
- **Tie and alternation**: both req with len=3, held through done → grant order s0, s1, s0; each burst 4 beats; 2 idle cycles between bursts; `s1_ready` never high during s0 bursts.
- **Back-pressure**: `fifo_full` high for 5 cycles mid-burst of len=7 → ready and wr_en low those 5 cycles, no beat lost or duplicated, total 8 writes.
- **Max length**: len=1023 → exactly 1024 writes, `beat_cnt` reaches 1023 without wrap, done asserted once.
- **Reset mid-burst**: rst_n low after beat 5 of len=15 → all outputs 0 immediately, no done; after release, s1 alone requests and gets the grant first.
- **Tag (with `MAT_FIFO_ARB_TAG_EN`)**: alternate bursts → `fifo_wr_data` MSB 0 for s0 beats and 1 for s1 beats.

Source files
------------

// File: rtl/mat_fifo_pkg.sv
// mat_fifo_pkg: shared FSM encodings, source indices and default sizes for the
// mat_fifo write arbiter.
package mat_fifo_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;
    localparam int LEN_WIDTH_DEF = 10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; a tie goes to the source opposite last_src.
module rr_arb2
    import mat_fifo_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_src,
    output logic gnt_valid,
    output logic gnt_idx
);
    assign gnt_valid = req0 | req1;
    assign gnt_idx   = (req0 && req1) ? ((last_src == SRC0) ? SRC1 : SRC0)
                                      : (req1 ? SRC1 : SRC0);
endmodule

// File: rtl/mat_fifo_wr_arb.sv
// mat_fifo_wr_arb: two-requester burst write arbiter feeding the shared mat_fifo.
// Define MAT_FIFO_ARB_TAG_EN to widen fifo_wr_data by one MSB carrying cur_src.
module mat_fifo_wr_arb
    import mat_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_req,
    input  logic                  s1_req,
    input  logic [LEN_WIDTH-1:0]  s0_len,
    input  logic [LEN_WIDTH-1:0]  s1_len,
    input  logic                  s0_valid,
    input  logic                  s1_valid,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s0_ready,
    output logic                  s1_ready,
    output logic                  s0_done,
    output logic                  s1_done,
    output logic                  fifo_wr_en,
`ifdef MAT_FIFO_ARB_TAG_EN
    output logic [DATA_WIDTH:0]   fifo_wr_data,
`else
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
`endif
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  cur_src
);
    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  last_src;
    logic                  gnt_valid;
    logic                  gnt_idx;
    logic                  burst;
    logic                  rdy;
    logic                  g_valid;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  last_beat;

    rr_arb2 u_arb (
        .req0      (s0_req),
        .req1      (s1_req),
        .last_src  (last_src),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // full gates ready combinationally so a stalled FIFO never sees a write
    assign burst      = (state == ST_BURST);
    assign rdy        = burst && !fifo_full;
    assign s0_ready   = rdy && (cur_src == SRC0);
    assign s1_ready   = rdy && (cur_src == SRC1);
    assign g_valid    = (cur_src == SRC1) ? s1_valid : s0_valid;
    assign g_data     = (cur_src == SRC1) ? s1_data : s0_data;
    assign fifo_wr_en = rdy && g_valid;
    assign last_beat  = fifo_wr_en && (beat_cnt == len_q);
    assign s0_done    = (state == ST_DONE) && (cur_src == SRC0);
    assign s1_done    = (state == ST_DONE) && (cur_src == SRC1);
    assign busy       = burst;
`ifdef MAT_FIFO_ARB_TAG_EN
    assign fifo_wr_data = burst ? {cur_src, g_data} : '0;
`else
    assign fifo_wr_data = burst ? g_data : '0;
`endif

    // beat_cnt holds on the last beat so an all-ones length never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            cur_src  <= SRC0;
            last_src <= SRC1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state    <= ST_BURST;
                        cur_src  <= gnt_idx;
                        len_q    <= (gnt_idx == SRC1) ? s1_len : s0_len;
                        beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (last_beat) begin
                        state    <= ST_DONE;
                        last_src <= cur_src;
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_fifo_wr_arb.sv
// tb_mat_fifo_wr_arb: directed and random checks of mat_fifo_wr_arb against a
// burst-level reference model (phase, owner, beats remaining).
module tb_mat_fifo_wr_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       r [2];
    logic       v [2];
    logic [9:0] ln [2];
    logic [7:0] dc [2];
    logic       full;
    logic       s0_ready, s1_ready, s0_done, s1_done, fifo_wr_en, busy, cur_src;
`ifdef MAT_FIFO_ARB_TAG_EN
    logic [8:0] fifo_wr_data;
`else
    logic [7:0] fifo_wr_data;
`endif

    int nchk = 0, nfail = 0;
    int ph, own, last, left;
    int nwr = 0, nd0 = 0, nd1 = 0;
    logic pbusy = 1'b0;
    int grants[$];

    always #5 clk = ~clk;

    mat_fifo_wr_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s0_req       (r[0]),
        .s1_req       (r[1]),
        .s0_len       (ln[0]),
        .s1_len       (ln[1]),
        .s0_valid     (v[0]),
        .s1_valid     (v[1]),
        .s0_data      (dc[0]),
        .s1_data      (dc[1]),
        .s0_ready     (s0_ready),
        .s1_ready     (s1_ready),
        .s0_done      (s0_done),
        .s1_done      (s1_done),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (full),
        .busy         (busy),
        .cur_src      (cur_src)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        ph = 0; own = 0; last = 1; left = 0;
    endtask

    function automatic logic [31:0] exp_data(int s);
`ifdef MAT_FIFO_ARB_TAG_EN
        return {23'd0, s[0], dc[s]};
`else
        return {24'd0, dc[s]};
`endif
    endfunction

    // one clock: check outputs at negedge, then advance the model past the edge
    task automatic tick();
        logic e0, e1, ew;
        logic [31:0] ed;
        @(negedge clk);
        e0 = (ph == 1) && (own == 0) && !full;
        e1 = (ph == 1) && (own == 1) && !full;
        ew = (e0 && v[0]) || (e1 && v[1]);
        ed = (ph == 1) ? exp_data(own) : 32'd0;
        chk("s0_ready", s0_ready, e0);
        chk("s1_ready", s1_ready, e1);
        chk("fifo_wr_en", fifo_wr_en, ew);
        chk("fifo_wr_data", fifo_wr_data, ed);
        chk("s0_done", s0_done, (ph == 2) && (own == 0));
        chk("s1_done", s1_done, (ph == 2) && (own == 1));
        chk("busy", busy, ph == 1);
        chk("cur_src", cur_src, own[0]);
        if (fifo_wr_en === 1'b1) nwr++;
        if (s0_done === 1'b1) nd0++;
        if (s1_done === 1'b1) nd1++;
        if (busy === 1'b1 && !pbusy) grants.push_back(int'(cur_src));
        pbusy = busy;
        @(posedge clk);
        #1;
        if (!rst_n) mreset();
        else if (ph == 0) begin
            if (r[0] || r[1]) begin
                own  = (r[0] && r[1]) ? 1 - last : (r[1] ? 1 : 0);
                left = int'(ln[own]) + 1;
                ph   = 1;
            end
        end else if (ph == 1) begin
            if (ew) begin
                dc[own] = dc[own] + 8'd1;
                left--;
                if (left == 0) begin
                    ph = 2;
                    last = own;
                end
            end
        end else ph = 0;
    endtask

    task automatic run_idle(int n);
        int k = 0;
        while (ph != 0 && k < n) begin
            tick();
            k++;
        end
        chk("idle_timeout", ph == 0, 1'b1);
    endtask

    task automatic drv();
        for (int n = 0; n < 2; n++) begin
            if (ph != 0 && own == n) r[n] = 1'b0;
            else if (!r[n] && $urandom_range(3) == 0) begin
                r[n]  = 1'b1;
                ln[n] = 10'($urandom_range(7));
            end
            v[n] = $urandom_range(3) != 0;
        end
        full = $urandom_range(4) == 0;
    endtask

    initial begin
        int base, d0, stall, k;
        rst_n = 1'b0; full = 1'b0;
        for (int n = 0; n < 2; n++) begin
            r[n] = 1'b0; v[n] = 1'b0; ln[n] = '0; dc[n] = '0;
        end
        mreset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // tie: both hold req, s0 wins first because last_src resets to 1
        grants.delete();
        r[0] = 1'b1; r[1] = 1'b1; ln[0] = 10'd3; ln[1] = 10'd3; v[0] = 1'b1; v[1] = 1'b1;
        k = 0;
        while (grants.size() < 3 && k < 60) begin
            tick();
            k++;
        end
        r[0] = 1'b0; r[1] = 1'b0;
        run_idle(20);
        chk("tie_grants", grants.size(), 3);
        if (grants.size() >= 3) begin
            chk("tie_g0", grants[0], 0);
            chk("tie_g1", grants[1], 1);
            chk("tie_g2", grants[2], 0);
        end
        v[0] = 1'b0; v[1] = 1'b0;
        tick();

        // single burst of 16, data 1..16
        base = nwr; d0 = nd0; dc[0] = 8'd1;
        r[0] = 1'b1; ln[0] = 10'd15; v[0] = 1'b1;
        tick();
        r[0] = 1'b0;
        run_idle(40);
        chk("single_writes", nwr - base, 16);
        chk("single_done", nd0 - d0, 1);
        chk("single_last_data", dc[0], 8'd17);

        // back-pressure: full for 5 cycles after 3 beats
        base = nwr; stall = 0;
        r[0] = 1'b1; ln[0] = 10'd7;
        tick();
        r[0] = 1'b0;
        k = 0;
        while (nwr - base < 3 && k < 20) begin
            tick();
            k++;
        end
        full = 1'b1;
        repeat (5) begin
            tick();
            if (fifo_wr_en === 1'b0 && s0_ready === 1'b0) stall++;
        end
        full = 1'b0;
        run_idle(30);
        chk("bp_stall", stall, 5);
        chk("bp_writes", nwr - base, 8);

        // max length
        base = nwr; d0 = nd0;
        r[0] = 1'b1; ln[0] = 10'h3ff;
        tick();
        r[0] = 1'b0;
        run_idle(1100);
        chk("max_writes", nwr - base, 1024);
        chk("max_done", nd0 - d0, 1);

        // reset mid-burst after beat 5
        base = nwr; d0 = nd0;
        r[0] = 1'b1; ln[0] = 10'd15;
        tick();
        r[0] = 1'b0;
        k = 0;
        while (nwr - base < 5 && k < 20) begin
            tick();
            k++;
        end
        #2 rst_n = 1'b0;
        #1;
        mreset();
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_ready", s0_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", fifo_wr_data, 32'd0);
        chk("rst_cur_src", cur_src, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        v[0] = 1'b0;
        tick();
        chk("rst_no_done", nd0 - d0, 0);
        r[1] = 1'b1; ln[1] = 10'd2; v[1] = 1'b1;
        tick();
        r[1] = 1'b0;
        chk("post_rst_grant_src", cur_src, 1'b1);
        chk("post_rst_grant_busy", busy, 1'b1);
        run_idle(20);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drv();
            tick();
        end
        r[0] = 1'b0; r[1] = 1'b0; v[0] = 1'b1; v[1] = 1'b1; full = 1'b0;
        run_idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
